image_rd_seq: RTL and testbench

//  Read sequencer for the image memory. Takes one 2-D window command (base, width, height, stride).

---
 rtl/image_rd_seq.sv | 141 ++++++++++++++
 tb/tb_image_rd_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/image_rd_seq.sv
// Read sequencer for the image memory: walks a 2-D window of group words, tracks the fixed
// 3-cycle read latency and streams returned words (with last tag) through a credit-limited FIFO.
module image_rd_seq #(
    parameter int GROUP_NB   = 4,
    parameter int IMG_WIDTH  = 16,
    parameter int MEM_AWIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_val,
    output logic                          cfg_rdy,
    input  logic [MEM_AWIDTH-1:0]         cfg_base,
    input  logic [MEM_AWIDTH-1:0]         cfg_width,
    input  logic [MEM_AWIDTH-1:0]         cfg_height,
    input  logic [MEM_AWIDTH-1:0]         cfg_stride,
    input  logic                          mem_wr_busy,
    output logic                          mem_rd_val,
    output logic [MEM_AWIDTH-1:0]         mem_rd_addr,
    input  logic [GROUP_NB*IMG_WIDTH-1:0] mem_rd_data,
    output logic                          str_val,
    input  logic                          str_rdy,
    output logic [GROUP_NB*IMG_WIDTH-1:0] str_data,
    output logic                          str_last,
    output logic                          done
);
    localparam int DW = GROUP_NB * IMG_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [MEM_AWIDTH-1:0] A_ONE = MEM_AWIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nxt;

    logic [MEM_AWIDTH-1:0] width_r, height_r, stride_r;
    logic [MEM_AWIDTH-1:0] col, row, row_addr, addr;
    logic                  zero_done;
    logic [3:1]            vld_pipe, last_pipe;

    logic [DW:0]           fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count, occ;
    logic [1:0]            inflight;

    logic issue, accept, cfg_nz, last_word, credit, drained, fifo_empty, push, pop;
    logic [DW:0] head;

    assign inflight   = 2'(vld_pipe[1]) + 2'(vld_pipe[2]) + 2'(vld_pipe[3]);
    assign occ        = count + CW'(inflight);
    assign credit     = occ < CW'(FIFO_DEPTH);
    assign fifo_empty = (count == '0);
    assign drained    = (state == DRAIN) && (inflight == 2'd0) && fifo_empty;
    assign cfg_rdy    = (state == IDLE) || drained;
    assign accept     = cfg_val && cfg_rdy;
    assign cfg_nz     = (cfg_width != '0) && (cfg_height != '0);
    assign last_word  = (col == width_r - A_ONE) && (row == height_r - A_ONE);
    assign done       = zero_done || drained;

    assign mem_rd_val  = issue;
    assign mem_rd_addr = addr;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE:  if (accept && cfg_nz) state_nxt = RUN;
            RUN: begin
                issue = ~mem_wr_busy & credit;
                if (issue && last_word) state_nxt = DRAIN;
            end
            DRAIN: if (drained) state_nxt = (accept && cfg_nz) ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            zero_done <= 1'b0;
            width_r   <= '0;
            height_r  <= '0;
            stride_r  <= '0;
            col       <= '0;
            row       <= '0;
            row_addr  <= '0;
            addr      <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            state     <= state_nxt;
            zero_done <= accept && !cfg_nz;
            // Tracks the memory latency; stage 3 lines up with mem_rd_data
            vld_pipe  <= {vld_pipe[2:1], issue};
            last_pipe <= {last_pipe[2:1], issue && last_word};
            if (accept) begin
                width_r  <= cfg_width;
                height_r <= cfg_height;
                stride_r <= cfg_stride;
                col      <= '0;
                row      <= '0;
                row_addr <= cfg_base;
                addr     <= cfg_base;
            end else if (issue) begin
                if (col == width_r - A_ONE) begin
                    col      <= '0;
                    row      <= row + A_ONE;
                    row_addr <= row_addr + stride_r;
                    addr     <= row_addr + stride_r;
                end else begin
                    col  <= col + A_ONE;
                    addr <= addr + A_ONE;
                end
            end
        end
    end

    // First-word fall-through: an empty FIFO presents the returning word directly,
    // so a same-cycle push and pop leaves the count unchanged.
    assign push     = vld_pipe[3];
    assign head     = fifo_empty ? {last_pipe[3], mem_rd_data} : fifo_mem[rd_ptr];
    assign str_val  = !fifo_empty || vld_pipe[3];
    assign str_data = head[DW-1:0];
    assign str_last = head[DW] && str_val;
    assign pop      = str_val && str_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {last_pipe[3], mem_rd_data};
    end
endmodule

// File: tb/tb_image_rd_seq.sv
// Directed bench for image_rd_seq: a 3-cycle memory model, negedge monitor logs, one task per scenario.
module tb_image_rd_seq;
    logic        clk = 0, rst = 1;
    logic        cfg_val = 0, cfg_rdy;
    logic [15:0] cfg_base = 0, cfg_width = 0, cfg_height = 0, cfg_stride = 0;
    logic        mem_wr_busy = 0, mem_rd_val;
    logic [15:0] mem_rd_addr;
    logic [63:0] mem_rd_data, str_data;
    logic        str_val, str_rdy = 1, str_last, done;

    int checks = 0, failures = 0, cyc = 0;
    int iss_tot = 0, pop_tot = 0;
    bit ovf = 0;
    logic [15:0] iss_addr[$];
    int          iss_cyc[$], out_cyc[$], done_cyc[$];
    logic [63:0] out_data[$];
    logic        out_last[$];
    logic        v1 = 0, v2 = 0, v3 = 0;
    logic [15:0] a1 = 0, a2 = 0, a3 = 0;

    image_rd_seq dut (
        .clk(clk), .rst(rst), .cfg_val(cfg_val), .cfg_rdy(cfg_rdy),
        .cfg_base(cfg_base), .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_stride(cfg_stride),
        .mem_wr_busy(mem_wr_busy), .mem_rd_val(mem_rd_val), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .str_val(str_val), .str_rdy(str_rdy), .str_data(str_data),
        .str_last(str_last), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [15:0] a);
        return {a ^ 16'h5A5A, a + 16'h1111, ~a, a};
    endfunction

    // Memory keeps running through reset so stale returns reach the DUT
    always @(posedge clk) begin
        cyc <= cyc + 1;
        v1 <= mem_rd_val; v2 <= v1; v3 <= v2;
        a1 <= mem_rd_addr; a2 <= a1; a3 <= a2;
    end
    assign mem_rd_data = v3 ? mem_word(a3) : 64'h0;

    always @(negedge clk) begin
        if (rst) begin
            iss_tot <= 0;
            pop_tot <= 0;
        end else begin
            if (mem_rd_val) begin iss_addr.push_back(mem_rd_addr); iss_cyc.push_back(cyc); end
            if (str_val && str_rdy) begin
                out_data.push_back(str_data); out_last.push_back(str_last); out_cyc.push_back(cyc);
            end
            if (done) done_cyc.push_back(cyc);
            iss_tot <= iss_tot + int'(mem_rd_val);
            pop_tot <= pop_tot + int'(str_val && str_rdy);
            if (iss_tot - pop_tot > 8) ovf <= 1;
        end
    end

    task automatic clear_logs();
        iss_addr.delete(); iss_cyc.delete(); out_cyc.delete(); done_cyc.delete();
        out_data.delete(); out_last.delete();
    endtask

    // Called at posedge+1; returns with cyc = accept cycle + 1
    task automatic send_cmd(input logic [15:0] b, w, h, s, output int k);
        cfg_val = 1; cfg_base = b; cfg_width = w; cfg_height = h; cfg_stride = s;
        k = cyc;
        @(posedge clk); #1;
        cfg_val = 0;
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max && !ok; i++) begin
            @(posedge clk); #1;
            if (done_cyc.size() > 0) ok = 1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (cfg_rdy !== 1'b1)  begin failures++; $display("FAIL reset_cfg_rdy got=%b exp=1", cfg_rdy); end
        checks++; if (mem_rd_val !== 0)  begin failures++; $display("FAIL reset_rd_val got=%b exp=0", mem_rd_val); end
        checks++; if (mem_rd_addr !== 0) begin failures++; $display("FAIL reset_rd_addr got=%h exp=0", mem_rd_addr); end
        checks++; if (str_val !== 0)     begin failures++; $display("FAIL reset_str_val got=%b exp=0", str_val); end
        checks++; if (str_last !== 0)    begin failures++; $display("FAIL reset_str_last got=%b exp=0", str_last); end
        checks++; if (done !== 0)        begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int k; bit ok;
        logic [15:0] exp_a[8] = '{16'h0010, 16'h0011, 16'h0012, 16'h0013,
                                  16'h0110, 16'h0111, 16'h0112, 16'h0113};
        clear_logs();
        send_cmd(16'h0010, 16'd4, 16'd2, 16'h0100, k);
        wait_done(100, ok);
        repeat (3) @(posedge clk); #1;
        checks++; if (!ok) begin failures++; $display("FAIL basic_done_timeout got=0 exp=1"); end
        checks++; if (iss_addr.size() != 8) begin failures++; $display("FAIL basic_issues got=%0d exp=8", iss_addr.size()); end
        checks++; if (out_data.size() != 8) begin failures++; $display("FAIL basic_words got=%0d exp=8", out_data.size()); end
        if (iss_addr.size() == 8 && out_data.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (iss_addr[i] !== exp_a[i]) begin failures++; $display("FAIL basic_addr[%0d] got=%h exp=%h", i, iss_addr[i], exp_a[i]); end
                checks++; if (out_data[i] !== mem_word(exp_a[i])) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, out_data[i], mem_word(exp_a[i])); end
                checks++; if (out_last[i] !== (i == 7)) begin failures++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, out_last[i], i == 7); end
            end
            checks++; if (iss_cyc[0] != k + 1) begin failures++; $display("FAIL basic_first_issue got=%0d exp=%0d", iss_cyc[0], k + 1); end
            checks++; if (iss_cyc[7] != k + 8) begin failures++; $display("FAIL basic_throughput got=%0d exp=%0d", iss_cyc[7], k + 8); end
            checks++; if (out_cyc[0] != iss_cyc[0] + 3) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", out_cyc[0], iss_cyc[0] + 3); end
            checks++; if (done_cyc.size() != 1 || done_cyc[0] != out_cyc[7] + 1) begin
                failures++; $display("FAIL basic_done_cycle got_n=%0d exp=%0d", done_cyc.size(), out_cyc[7] + 1); end
        end
    endtask

    task automatic test_zero_size();
        int k;
        clear_logs();
        send_cmd(16'h0020, 16'd0, 16'd5, 16'd1, k);
        repeat (4) @(posedge clk); #1;
        checks++; if (done_cyc.size() != 1 || done_cyc[0] != k + 1) begin
            failures++; $display("FAIL zero_done got_n=%0d exp_cycle=%0d", done_cyc.size(), k + 1); end
        checks++; if (iss_addr.size() != 0) begin failures++; $display("FAIL zero_issues got=%0d exp=0", iss_addr.size()); end
        checks++; if (out_data.size() != 0) begin failures++; $display("FAIL zero_words got=%0d exp=0", out_data.size()); end
    endtask

    task automatic test_wrap();
        int k; bit ok;
        logic [15:0] exp_a[4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        clear_logs();
        send_cmd(16'hFFFE, 16'd4, 16'd1, 16'd0, k);
        wait_done(100, ok);
        checks++; if (!ok || out_data.size() != 4 || iss_addr.size() != 4) begin
            failures++; $display("FAIL wrap_counts got_words=%0d got_issues=%0d exp=4", out_data.size(), iss_addr.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (iss_addr[i] !== exp_a[i] || out_data[i] !== mem_word(exp_a[i]) || out_last[i] !== (i == 3)) begin
                failures++; $display("FAIL wrap[%0d] got_addr=%h exp_addr=%h got_data=%h", i, iss_addr[i], exp_a[i], out_data[i]); end
        end
    endtask

    task automatic test_backpressure();
        int k; bit ok;
        clear_logs();
        str_rdy = 0;
        send_cmd(16'h0200, 16'd16, 16'd1, 16'd0, k);
        repeat (30) @(posedge clk); #1;
        checks++; if (iss_addr.size() != 8) begin failures++; $display("FAIL bp_stall_issues got=%0d exp=8", iss_addr.size()); end
        checks++; if (str_val !== 1'b1 || str_data !== mem_word(16'h0200) || str_last !== 1'b0) begin
            failures++; $display("FAIL bp_hold got_val=%b got_data=%h exp_data=%h", str_val, str_data, mem_word(16'h0200)); end
        str_rdy = 1;
        wait_done(100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_done_timeout got=0 exp=1"); end
        checks++; if (out_data.size() != 16 || iss_addr.size() != 16) begin
            failures++; $display("FAIL bp_counts got_words=%0d got_issues=%0d exp=16", out_data.size(), iss_addr.size()); end
        else for (int i = 0; i < 16; i++) begin
            checks++; if (iss_addr[i] !== 16'h0200 + 16'(i) || out_data[i] !== mem_word(16'h0200 + 16'(i)) || out_last[i] !== (i == 15)) begin
                failures++; $display("FAIL bp_word[%0d] got_addr=%h got_data=%h exp_addr=%h", i, iss_addr[i], out_data[i], 16'h0200 + 16'(i)); end
        end
        checks++; if (ovf) begin failures++; $display("FAIL bp_overflow got=1 exp=0"); end
    endtask

    task automatic test_wr_busy();
        int k; bit ok;
        int exp_c[6];
        clear_logs();
        send_cmd(16'h0300, 16'd6, 16'd1, 16'd0, k);
        @(posedge clk); #1;
        mem_wr_busy = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (mem_rd_val !== 0 || mem_rd_addr !== 16'h0301) begin
                failures++; $display("FAIL busy_hold[%0d] got_val=%b got_addr=%h exp_addr=0301", i, mem_rd_val, mem_rd_addr); end
            @(posedge clk); #1;
        end
        mem_wr_busy = 0;
        wait_done(100, ok);
        exp_c = '{k + 1, k + 5, k + 6, k + 7, k + 8, k + 9};
        checks++; if (!ok || out_data.size() != 6 || iss_addr.size() != 6) begin
            failures++; $display("FAIL busy_counts got_words=%0d got_issues=%0d exp=6", out_data.size(), iss_addr.size()); end
        else for (int i = 0; i < 6; i++) begin
            checks++; if (iss_cyc[i] != exp_c[i] || iss_addr[i] !== 16'h0300 + 16'(i) || out_data[i] !== mem_word(16'h0300 + 16'(i)) || out_last[i] !== (i == 5)) begin
                failures++; $display("FAIL busy_word[%0d] got_cyc=%0d exp_cyc=%0d got_addr=%h", i, iss_cyc[i], exp_c[i], iss_addr[i]); end
        end
    endtask

    task automatic test_reset_abort();
        int k; bit ok;
        clear_logs();
        send_cmd(16'h0400, 16'd8, 16'd1, 16'd0, k);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        checks++; if (cfg_rdy !== 1 || mem_rd_val !== 0 || mem_rd_addr !== 0 || str_val !== 0 || str_last !== 0 || done !== 0) begin
            failures++; $display("FAIL abort_outputs got rdy=%b val=%b addr=%h sval=%b last=%b done=%b", cfg_rdy, mem_rd_val, mem_rd_addr, str_val, str_last, done); end
        rst = 0;
        clear_logs();
        send_cmd(16'h0500, 16'd3, 16'd1, 16'd0, k);
        wait_done(100, ok);
        checks++; if (!ok || out_data.size() != 3 || iss_addr.size() != 3) begin
            failures++; $display("FAIL abort_counts got_words=%0d got_issues=%0d exp=3", out_data.size(), iss_addr.size()); end
        else for (int i = 0; i < 3; i++) begin
            checks++; if (iss_addr[i] !== 16'h0500 + 16'(i) || out_data[i] !== mem_word(16'h0500 + 16'(i)) || out_last[i] !== (i == 2)) begin
                failures++; $display("FAIL abort_word[%0d] got_data=%h exp=%h", i, out_data[i], mem_word(16'h0500 + 16'(i))); end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk); #1;
        test_reset();
        test_basic();
        test_zero_size();
        test_wrap();
        test_backpressure();
        test_wr_busy();
        test_reset_abort();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
